rr_sel_mux: RTL
===============

Name: rr_sel_mux

Overview:
- Parametrised N-channel, WIDTH-bit registered selector for the microprocessor datapath. It supersedes the plain 2:1 8-bit operand mux.
- Selects one of NUM_CH valid/ready input channels, either by an explicit select (direct mode) or by round-robin arbitration.
- Registers the chosen word into a one-entry output stage with valid/ready handshake.
- Feeds shared consumers such as the ALU operand bus and the register-file write port.

Parameters:
- WIDTH, 8, data word width in bits
- NUM_CH, 4, number of input channels (>=2)
- SEL_W, $clog2(NUM_CH), width of sel and out_ch

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- mode  input  1  0 = direct select, 1 = round-robin
- sel  input  SEL_W  channel index used in direct mode
- in_data  input  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  NUM_CH  per-channel data valid
- in_ready  output  NUM_CH  per-channel accept strobe
- out_data  output  WIDTH  registered selected word
- out_ch  output  SEL_W  index of the channel that produced out_data
- out_valid  output  1  out_data holds an untaken word
- out_ready  input  1  downstream accepts out_data

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, out_ch=0, rr_ptr=NUM_CH-1 so channel 0 has top priority first. in_ready is combinational and is 0 while out_valid=0 with no grant.
- load = !out_valid | out_ready. The output stage can take a new word this cycle.
- Grant, direct mode:
  - grant_vld = (sel < NUM_CH) & in_valid[sel]; grant_idx = sel.
  - sel >= NUM_CH gives no grant.
- Grant, RR mode:
  - Search channels rr_ptr+1, rr_ptr+2, ... modulo NUM_CH. grant_idx is the first with in_valid set.
  - grant_vld = |in_valid.
- in_ready[i] = load & grant_vld & (grant_idx == i). At most one bit is high; all bits are 0 when !load.
- Transfer (load & grant_vld), at the next edge:
  - out_data <= in_data[grant_idx], out_ch <= grant_idx, out_valid <= 1.
  - In RR mode only, rr_ptr <= grant_idx.
- load & !grant_vld, at the next edge: out_valid <= 0; out_data and out_ch hold their last values.
- !load (stall): out_data, out_ch, out_valid and rr_ptr hold.
- Latency: 1 cycle from input handshake to out_valid. Throughput: 1 word per cycle with out_ready held high.
- Simultaneous out_ready=1 and a new grant: the old word retires and the new word loads on the same edge, with no bubble.
- Mode switch:
  - Takes effect in the cycle mode changes. It never disturbs a word already in the output stage.
  - rr_ptr is retained across direct-mode periods.
- in_valid deasserting without in_ready is legal. Arbitration re-evaluates every cycle and no request is sticky.
- rr_ptr wrap-around: NUM_CH-1 is followed by 0.
- Reset asserted mid-stall discards the held word. out_valid is 0 on the cycle after reset deasserts.

Decomposition:
- Shared header mux_defs.vh holds MODE_DIRECT=1'b0 and MODE_RR=1'b1. The channel slicing macro also lives there and is reused by other multi-channel blocks.
- One sub-module, rr_arbiter, is natural:
  - Combinational rotating-priority search.
  - Inputs: req[NUM_CH], ptr[SEL_W]. Outputs: gnt_vld, gnt_idx.
  - Instantiated inside rr_sel_mux. The top level owns the rr_ptr register and the output stage.
- Target size is roughly 150-250 lines total.

Test Plan (NUM_CH=4, WIDTH=8):
1. Direct basic: mode=0, sel=2, in_valid=4'b0100, ch2 data=8'hA5, out_ready=1.
   - in_ready=4'b0100 that cycle.
   - Next cycle out_valid=1, out_data=8'hA5, out_ch=2.
2. Direct miss: mode=0, sel=1, in_valid=4'b1101 -> in_ready=4'b0000; out_valid drops to 0 next cycle; out_data holds its previous value.
3. RR fairness: mode=1, after reset, in_valid=4'b1111 constant, data ch_i=8'h10+i, out_ready=1.
   - out_ch sequence is 0,1,2,3,0.
   - out_data sequence is 10,11,12,13,10.
4. RR skip with wrap: rr_ptr=1 (last grant ch1), in_valid=4'b1001 -> grants ch3 then ch0 on consecutive cycles.
5. Backpressure: out_valid=1 with out_data=8'h3C, out_ready=0 for 3 cycles while in_valid=4'b1111.
   - All in_ready=0; out_data stays 8'h3C.
   - Raising out_ready retires 8'h3C and loads the next RR grant on the same edge.
6. Reset mid-operation: assert rst_n=0 while out_valid=1 and stalled.
   - out_valid=0, out_data=0, out_ch=0 immediately, without waiting for a clock edge.
   - After release, the first RR grant with in_valid=4'b1111 is ch0.

Source files
------------

// File: rtl/rr_sel_mux_pkg.sv
// Shared definitions for the round-robin / direct channel selector.
package rr_sel_mux_pkg;

  // Selection mode encoding on the mode input.
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Wrap a channel offset back into the range 0..n-1.
  function automatic int unsigned ch_wrap(input int unsigned idx, input int unsigned n);
    return idx % n;
  endfunction

endpackage

// File: rtl/rr_sel_mux_arbiter.sv
// Rotating-priority search: the channel just after ptr has top priority,
// continuing upward and wrapping from NUM_CH-1 to 0.
module rr_arbiter
  import rr_sel_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic              gnt_vld,
  output logic [SEL_W-1:0]  gnt_idx
);

  // Walk offsets from farthest to nearest so the nearest requester overwrites.
  always_comb begin
    int unsigned idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = ch_wrap(32'(ptr) + 32'(k), 32'(NUM_CH));
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_sel_mux.sv
// N-channel registered selector: direct or round-robin channel choice feeding
// a one-entry valid/ready output stage.
module rr_sel_mux
  import rr_sel_mux_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             load;
  logic             rr_vld;
  logic [SEL_W-1:0] rr_idx;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .gnt_vld (rr_vld),
    .gnt_idx (rr_idx)
  );

  // Pick the granted channel for this cycle; an out-of-range sel never grants.
  always_comb begin
    load = !out_valid_q || out_ready;
    if (mode == MODE_RR) begin
      grant_vld = rr_vld;
      grant_idx = rr_idx;
    end else begin
      grant_idx = sel;
      grant_vld = (32'(sel) < 32'(NUM_CH)) && in_valid[sel];
    end
  end

  // One-hot accept strobe, only when the output stage can take the word.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      in_ready[i] = load && grant_vld && (grant_idx == SEL_W'(i));
    end
  end

  // Next-state of the output stage and the round-robin pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      if (grant_vld) begin
        out_data_d  = in_data[32'(grant_idx)*WIDTH +: WIDTH];
        out_ch_d    = grant_idx;
        out_valid_d = 1'b1;
        // Direct-mode traffic leaves the rotation position untouched.
        if (mode == MODE_RR) begin
          rr_ptr_d = grant_idx;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Output stage and pointer registers; pointer resets so channel 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= SEL_W'(NUM_CH - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule
